// File: rtl/timer_irq_ctrl_if.sv
// Bus bundle between the timer interrupt controller and its environment:
// timer-side request/clear lines plus the CPU dispatch/acknowledge handshake.
interface timer_irq_ctrl_if;
    logic [3:0] irq_in;
    logic [3:0] irq_mask;
    logic [3:0] irq_clear;
    logic [3:0] pending;
    logic       cpu_irq;
    logic [1:0] cpu_vector;
    logic       cpu_ack;
    logic       ack_timeout;
    logic       ack_timeout_clear;

    // Controller side
    modport slave (
        input  irq_in, irq_mask, cpu_ack, ack_timeout_clear,
        output irq_clear, pending, cpu_irq, cpu_vector, ack_timeout
    );

    // Environment side (timers + CPU)
    modport master (
        output irq_in, irq_mask, cpu_ack, ack_timeout_clear,
        input  irq_clear, pending, cpu_irq, cpu_vector, ack_timeout
    );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: latches rising edges of four timer interrupt
// lines, dispatches the lowest-numbered enabled pending source to the CPU,
// pulses the matching timer clear on acknowledge, and flags slow acknowledges.
module timer_irq_ctrl #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd255
) (
    input  logic              clk,
    input  logic              reset,
    timer_irq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    // Lowest set index of a 4-bit request vector (0 when empty).
    function automatic logic [1:0] lowest_idx(input logic [3:0] req);
        logic [1:0] idx;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // One-hot decode of a source index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  irq_prev_r;
    logic [3:0]  pending_r;
    logic [3:0]  irq_clear_r;
    logic        cpu_irq_r;
    logic [1:0]  cpu_vector_r;
    logic [15:0] wait_cnt_r;
    logic        ack_timeout_r;

    logic [3:0]  edge_s;
    logic [3:0]  req_s;
    logic [3:0]  clr_bits_s;
    logic        dispatch_s;
    logic        ack_s;
    logic        to_set_s;

    // Edge detect, enabled request set, and timeout expiry detection.
    always_comb begin
        edge_s   = bus.irq_in & ~irq_prev_r;
        req_s    = pending_r & bus.irq_mask;
        to_set_s = 1'b0;
        if ((state_r == ST_ASSERT) && !bus.cpu_ack &&
            (wait_cnt_r == (ACK_TIMEOUT - 16'd1))) begin
            to_set_s = 1'b1;
        end else begin
            to_set_s = 1'b0;
        end
    end

    // Dispatch FSM next-state logic; mask changes only matter in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        dispatch_s  = 1'b0;
        ack_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s != 4'd0) begin
                    state_nxt_s = ST_ASSERT;
                    dispatch_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (bus.cpu_ack) begin
                    state_nxt_s = ST_CLEAR;
                    ack_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_CLEAR: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Pending bit being retired by the current acknowledge.
    always_comb begin
        clr_bits_s = 4'd0;
        if (ack_s) begin
            clr_bits_s = onehot(cpu_vector_r);
        end else begin
            clr_bits_s = 4'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Input history and pending flags; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_r <= 4'd0;
            pending_r  <= 4'd0;
        end else begin
            irq_prev_r <= bus.irq_in;
            pending_r  <= (pending_r & ~clr_bits_s) | edge_s;
        end
    end

    // Registered CPU-facing outputs and the timer clear pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_irq_r    <= 1'b0;
            cpu_vector_r <= 2'd0;
            irq_clear_r  <= 4'd0;
        end else begin
            cpu_irq_r   <= (state_nxt_s == ST_ASSERT);
            irq_clear_r <= clr_bits_s;
            if (dispatch_s) begin
                cpu_vector_r <= lowest_idx(req_s);
            end
        end
    end

    // Acknowledge wait counter, saturating at the timeout value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 16'd0;
        end else if (dispatch_s) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_r == ST_ASSERT) && !bus.cpu_ack &&
                     (wait_cnt_r != ACK_TIMEOUT)) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end
    end

    // Sticky timeout flag; a new expiry beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_timeout_r <= 1'b0;
        end else begin
            ack_timeout_r <= to_set_s | (ack_timeout_r & ~bus.ack_timeout_clear);
        end
    end

    assign bus.pending     = pending_r;
    assign bus.irq_clear   = irq_clear_r;
    assign bus.cpu_irq     = cpu_irq_r;
    assign bus.cpu_vector  = cpu_vector_r;
    assign bus.ack_timeout = ack_timeout_r;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: a directed vector table, hand-written
// corner sequences, and randomized traffic compared against a behavioural model.
module tb_timer_irq_ctrl;

    localparam logic [15:0] TO = 16'd4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    timer_irq_ctrl_if bus();

    timer_irq_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: phase 0 = no dispatch, 1 = waiting for ack, 2 = clearing.
    logic [3:0] m_prev   = 4'd0;
    logic [3:0] m_pend   = 4'd0;
    logic [3:0] m_clr    = 4'd0;
    int         m_phase  = 0;
    logic [1:0] m_vec    = 2'd0;
    int         m_waited = 0;
    logic       m_to     = 1'b0;

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        ack;
        logic        toclr;
        logic [11:0] exp;   // {pending, irq_clear, cpu_irq, cpu_vector, ack_timeout}
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic rst, input logic [3:0] irq, input logic ack,
                                input logic [3:0] pend, input logic [3:0] clr,
                                input logic cirq, input logic [1:0] vec, input logic to);
        vec_t v;
        v.rst = rst; v.irq = irq; v.mask = 4'hF; v.ack = ack; v.toclr = 1'b0;
        v.exp = {pend, clr, cirq, vec, to};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_out();
        return {bus.pending, bus.irq_clear, bus.cpu_irq, bus.cpu_vector, bus.ack_timeout};
    endfunction

    function automatic logic [11:0] model_out();
        return {m_pend, m_clr, (m_phase == 1), m_vec, m_to};
    endfunction

    // Advance the reference model by one clock with the given inputs.
    task automatic model_step(input logic rst, input logic [3:0] irq, input logic [3:0] mask,
                              input logic ack, input logic toclr);
        logic [3:0] edges;
        logic [3:0] req;
        logic [3:0] clr_now;
        logic       set_to;
        if (rst) begin
            m_prev = 4'd0; m_pend = 4'd0; m_clr = 4'd0; m_phase = 0;
            m_vec = 2'd0; m_waited = 0; m_to = 1'b0;
        end else begin
            edges   = irq & ~m_prev;
            req     = m_pend & mask;
            clr_now = 4'd0;
            set_to  = 1'b0;
            if (m_phase == 0) begin
                if (req != 4'd0) begin
                    for (int i = 3; i >= 0; i--) begin
                        if (req[i]) m_vec = 2'(i);
                    end
                    m_phase  = 1;
                    m_waited = 0;
                end
            end else if (m_phase == 1) begin
                if (ack) begin
                    clr_now = 4'b0001 << m_vec;
                    m_phase = 2;
                end else begin
                    m_waited++;
                    if (m_waited == int'(TO)) set_to = 1'b1;
                end
            end else begin
                m_phase = 0;
            end
            m_pend = (m_pend & ~clr_now) | edges;
            m_prev = irq;
            m_clr  = clr_now;
            m_to   = set_to | (m_to & ~toclr);
        end
    endtask

    // Drive inputs, advance one clock, sample after the edge and compare to the model.
    task automatic step(input logic rst, input logic [3:0] irq, input logic [3:0] mask,
                        input logic ack, input logic toclr);
        reset                 = rst;
        bus.irq_in            = irq;
        bus.irq_mask          = mask;
        bus.cpu_ack           = ack;
        bus.ack_timeout_clear = toclr;
        model_step(rst, irq, mask, ack, toclr);
        @(posedge clk);
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    logic [3:0] r_irq;
    logic [3:0] r_mask;
    logic       prev_irq;
    int         n_disp;
    int         got;

    initial begin
        bus.irq_in = 4'd0; bus.irq_mask = 4'hF; bus.cpu_ack = 1'b0; bus.ack_timeout_clear = 1'b0;

        // Basic dispatch, priority and ignored acks, with hand-derived expectations.
        tbl[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[1]  = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[2]  = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
        tbl[3]  = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
        tbl[4]  = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
        tbl[5]  = mk(1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0);
        tbl[6]  = mk(1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
        tbl[7]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
        tbl[8]  = mk(1'b0, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b0, 2'd2, 1'b0);
        tbl[9]  = mk(1'b0, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b0);
        tbl[10] = mk(1'b0, 4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b0, 2'd1, 1'b0);
        tbl[11] = mk(1'b0, 4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd1, 1'b0);
        tbl[12] = mk(1'b0, 4'b1010, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0);
        tbl[13] = mk(1'b0, 4'b1010, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0);
        tbl[14] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);
        tbl[15] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);

        for (int r = 0; r < 16; r++) begin
            step(tbl[r].rst, tbl[r].irq, tbl[r].mask, tbl[r].ack, tbl[r].toclr);
            check($sformatf("table_row%0d", r), 32'(dut_out()), 32'(tbl[r].exp));
        end

        // Masked source stays pending until unmasked.
        step(1'b0, 4'b0001, 4'b1110, 1'b0, 1'b0);
        check("s3_pend", 32'(bus.pending), 32'(4'b0001));
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b0001, 4'b1110, 1'b0, 1'b0);
            check("s3_masked", 32'({bus.cpu_irq, bus.pending}), 32'(5'b0_0001));
        end
        got = 0;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
            if (bus.cpu_irq && (bus.cpu_vector == 2'd0)) got = 1;
        end
        check("s3_unmask_dispatch", 32'(got), 32'(1));
        step(1'b0, 4'b0001, 4'hF, 1'b1, 1'b0);
        check("s3_clear", 32'(bus.irq_clear), 32'(4'b0001));
        step(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);

        // Timeout: flag rises 4 cycles after cpu_irq, dispatch stays, late ack completes.
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        check("s4_irq_up", 32'({bus.cpu_irq, bus.cpu_vector}), 32'(3'b1_11));
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
            check($sformatf("s4_to_k%0d", k), 32'(bus.ack_timeout), 32'(k == 4));
        end
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        check("s4_still_asserted", 32'({bus.cpu_irq, bus.ack_timeout}), 32'(2'b11));
        step(1'b0, 4'b1000, 4'hF, 1'b1, 1'b0);
        check("s4_late_ack", 32'({bus.cpu_irq, bus.irq_clear}), 32'(5'b0_1000));
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b1);
        check("s4_to_clear", 32'(bus.ack_timeout), 32'(0));
        // Set and clear in the same cycle: set wins, the held clear then drops it.
        step(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 4'b1000, 4'hF, 1'b0, 1'b1);
            check($sformatf("s4_setwins_k%0d", k), 32'(bus.ack_timeout), 32'(k == 4));
        end
        step(1'b0, 4'b1000, 4'hF, 1'b1, 1'b1);
        check("s4_to_dropped", 32'(bus.ack_timeout), 32'(0));
        step(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);

        // Reset in ASSERT aborts without a clear pulse; a held line re-pends.
        step(1'b0, 4'b0010, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'hF, 1'b0, 1'b0);
        check("s5_asserted", 32'({bus.cpu_irq, bus.cpu_vector}), 32'(3'b1_01));
        step(1'b1, 4'b0010, 4'hF, 1'b1, 1'b0);
        check("s5_reset_outs", 32'(dut_out()), 32'(12'd0));
        step(1'b0, 4'b0010, 4'hF, 1'b0, 1'b0);
        check("s5_repend", 32'({bus.pending, bus.irq_clear, bus.cpu_irq}), 32'(9'b0010_0000_0));
        step(1'b0, 4'b0010, 4'hF, 1'b0, 1'b0);
        check("s5_redispatch", 32'({bus.cpu_irq, bus.cpu_vector}), 32'(3'b1_01));
        step(1'b0, 4'b0010, 4'hF, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);

        // Level held: no re-dispatch while high, exactly one after a fresh rise.
        step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'hF, 1'b1, 1'b0);
        step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
            check("s6_held_quiet", 32'({bus.cpu_irq, bus.pending}), 32'(5'd0));
        end
        step(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);
        n_disp   = 0;
        prev_irq = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b0001, 4'hF, bus.cpu_irq, 1'b0);
            if (bus.cpu_irq && !prev_irq) n_disp++;
            prev_irq = bus.cpu_irq;
        end
        check("s6_one_dispatch", 32'(n_disp), 32'(1));

        // Randomized traffic against the model.
        r_irq  = 4'd0;
        r_mask = 4'hF;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) r_irq = r_irq ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) r_mask = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 199) == 0), r_irq, r_mask,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
